// File: rtl/spi_master.sv
// SPI master, mode 0, one byte per transfer, MSB first.
// Optional burst support is enabled by defining SPI_MASTER_BURST_EN,
// which adds the hold input and the HELD state (slave select kept low
// between consecutive bytes).
`timescale 1ns/1ps

module spi_master #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned SS_GAP  = 2
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       start,
    input  logic [7:0] tx_data,
`ifdef SPI_MASTER_BURST_EN
    input  logic       hold,
`endif
    input  logic       miso,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ss,
    output logic       mosi
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        TAIL,
        GAP
`ifdef SPI_MASTER_BURST_EN
        , HELD
`endif
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;
    logic [6:0] tx_sh;
    logic [7:0] rx_sh;
    logic       last_div;

    // End of an sclk half-period
    always_comb last_div = (cnt == 8'(CLK_DIV - 1));

    // Transfer sequencer with registered SPI and handshake outputs.
    // tx_sh holds only the bits not yet on mosi; bit 7 goes straight to mosi.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            ss      <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sh   <= tx_data[6:0];
                        mosi    <= tx_data[7];
                        bit_cnt <= 3'd7;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        ss      <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (last_div) begin
                        cnt   <= '0;
                        sclk  <= 1'b1;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (cnt == '0)
                        rx_sh <= {rx_sh[6:0], miso};
                    if (last_div) begin
                        cnt  <= '0;
                        sclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            state <= TAIL;
                        end else begin
                            bit_cnt <= bit_cnt - 3'd1;
                            mosi    <= tx_sh[6];
                            tx_sh   <= {tx_sh[5:0], 1'b0};
                            state   <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                TAIL: begin
                    if (last_div) begin
                        cnt     <= '0;
                        rx_data <= rx_sh;
                        done    <= 1'b1;
`ifdef SPI_MASTER_BURST_EN
                        if (hold) begin
                            busy  <= 1'b0;
                            state <= HELD;
                        end else begin
                            ss    <= 1'b1;
                            mosi  <= 1'b0;
                            state <= GAP;
                        end
`else
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= GAP;
`endif
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == 8'(SS_GAP - 1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef SPI_MASTER_BURST_EN
                HELD: begin
                    // ss is already low, so the first half-period is a LOW phase
                    if (start) begin
                        tx_sh   <= tx_data[6:0];
                        mosi    <= tx_data[7];
                        bit_cnt <= 3'd7;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= LOW;
                    end else if (!hold) begin
                        ss    <= 1'b1;
                        mosi  <= 1'b0;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: two instances (default timing and the fastest
// legal timing), a slave model per instance, and a scoreboard of expected
// bytes and completion cycles checked by a negedge monitor.
`timescale 1ns/1ps

module tb_spi_master;

    localparam int unsigned CD0 = 4, GAP0 = 2;
    localparam int unsigned CD1 = 2, GAP1 = 1;

    typedef struct packed {
        logic [7:0]  tx;
        logic [7:0]  rx;
        logic [31:0] done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic       start [2];
    logic [7:0] tx    [2];
    logic       miso  [2];
    logic [7:0] rx    [2];
    logic       busy  [2];
    logic       done  [2];
    logic       sclk  [2];
    logic       ss    [2];
    logic       mosi  [2];
`ifdef SPI_MASTER_BURST_EN
    logic       hold0;
`endif

    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    // slave model and monitor state
    logic [7:0]  sbyte    [2];
    int unsigned fcnt     [2];
    int unsigned rises    [2];
    int unsigned rises_ss [2];
    int unsigned sshi     [2];
    logic [7:0]  cap      [2];
    logic        psclk [2], pss [2], pmosi [2], pdone [2];
    logic [7:0]  prx   [2];
    exp_t sb0[$];
    exp_t sb1[$];

    spi_master #(.CLK_DIV(CD0), .SS_GAP(GAP0)) dut0 (
        .clk(clk), .rst_L(rst_L), .start(start[0]), .tx_data(tx[0]),
`ifdef SPI_MASTER_BURST_EN
        .hold(hold0),
`endif
        .miso(miso[0]), .rx_data(rx[0]), .busy(busy[0]), .done(done[0]),
        .sclk(sclk[0]), .ss(ss[0]), .mosi(mosi[0])
    );

    spi_master #(.CLK_DIV(CD1), .SS_GAP(GAP1)) dut1 (
        .clk(clk), .rst_L(rst_L), .start(start[1]), .tx_data(tx[1]),
`ifdef SPI_MASTER_BURST_EN
        .hold(1'b0),
`endif
        .miso(miso[1]), .rx_data(rx[1]), .busy(busy[1]), .done(done[1]),
        .sclk(sclk[1]), .ss(ss[1]), .mosi(mosi[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave presents bit 7 first and advances after each sclk fall
    always_comb begin
        for (int d = 0; d < 2; d++)
            miso[d] = (fcnt[d] < 8) ? sbyte[d][3'(7 - fcnt[d])] : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned lat(input int d);
        return 1 + 17 * ((d == 0) ? CD0 : CD1);
    endfunction

    // Monitor: protocol rules every cycle, scoreboard pop on each done
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        for (int d = 0; d < 2; d++) begin
            if (!rst_L) begin
                rises[d] = 0; rises_ss[d] = 0; cap[d] = '0; fcnt[d] = 0; sshi[d] = 0;
            end else begin
                if (!ss[d] && pss[d]) begin
                    chk($sformatf("d%0d_ss_gap_min", d), 32'(sshi[d] >= 1), 1);
                    rises[d] = 0; rises_ss[d] = 0; cap[d] = '0; fcnt[d] = 0;
                end
                if (ss[d]) sshi[d]++; else sshi[d] = 0;
                if (sclk[d] && !psclk[d]) begin
                    cap[d] = {cap[d][6:0], mosi[d]};
                    rises[d]++;
                    rises_ss[d]++;
                end
                if (!sclk[d] && psclk[d]) fcnt[d]++;
                if (ss[d]) begin
                    chk($sformatf("d%0d_mosi_idle", d), 32'(mosi[d]), 0);
                    chk($sformatf("d%0d_sclk_idle", d), 32'(sclk[d]), 0);
                end
                if (mosi[d] !== pmosi[d])
                    chk($sformatf("d%0d_mosi_chg_sclk_low", d), 32'(sclk[d]), 0);
                if (done[d]) begin
                    chk($sformatf("d%0d_done_width", d), 32'(pdone[d]), 0);
                    ok = 1'b0;
                    if (d == 0) begin
                        if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
                    end else begin
                        if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
                    end
                    if (!ok) begin
                        total++; bad++;
                        $display("FAIL d%0d_spurious_done: got done=1 expected no transfer", d);
                    end else begin
                        chk($sformatf("d%0d_rx_data", d), 32'(rx[d]), 32'(e.rx));
                        chk($sformatf("d%0d_mosi_byte", d), 32'(cap[d]), 32'(e.tx));
                        chk($sformatf("d%0d_rises", d), rises[d], 8);
                        chk($sformatf("d%0d_done_cycle", d), cyc, e.done_cyc);
                    end
                    rises[d] = 0; cap[d] = '0; fcnt[d] = 0;
                end else begin
                    chk($sformatf("d%0d_rx_hold", d), 32'(rx[d]), 32'(prx[d]));
                end
            end
            psclk[d] = sclk[d]; pss[d] = ss[d]; pmosi[d] = mosi[d];
            pdone[d] = done[d]; prx[d] = rx[d];
        end
    end

    // Issue one start at the current negedge and record the expectation
    task automatic issue(input int d, input logic [7:0] t, input logic [7:0] s,
                         output int unsigned c0);
        exp_t e;
        c0 = cyc;
        sbyte[d] = s;
        e.tx = t;
        e.rx = s;
        e.done_cyc = c0 + lat(d);
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        tx[d] = t;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        tx[d] = 8'($urandom);
    endtask

    task automatic wait_idle(input int d, input int unsigned c0, input bit chk_t);
        for (int k = 0; k < 400; k++) begin
            if (!busy[d]) break;
            @(negedge clk);
        end
        if (busy[d]) begin
            total++; bad++;
            $display("FAIL d%0d_busy_timeout: got busy=1 expected busy=0", d);
        end else if (chk_t) begin
            chk($sformatf("d%0d_busy_fall_cycle", d), cyc,
                c0 + lat(d) + ((d == 0) ? GAP0 : GAP1));
        end
    endtask

    task automatic xfer0(input logic [7:0] t, input logic [7:0] s, input bit inject);
        int unsigned c0;
        issue(0, t, s, c0);
        if (inject) begin
            repeat (9) @(negedge clk);
            start[0] = 1'b1;
            tx[0] = 8'hFF;
            @(negedge clk);
            start[0] = 1'b0;
        end
        wait_idle(0, c0, 1'b1);
        @(negedge clk);
        chk("d0_stay_idle", 32'(busy[0]), 0);
    endtask

    initial begin
        int unsigned c0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; tx[d] = '0; sbyte[d] = '0;
            fcnt[d] = 0; rises[d] = 0; rises_ss[d] = 0; sshi[d] = 0; cap[d] = '0;
        end
`ifdef SPI_MASTER_BURST_EN
        hold0 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ss", 32'(ss[0]), 1);
        chk("rst_busy", 32'(busy[0]), 0);
        rst_L = 1'b1;
        @(negedge clk);
        chk("idle_sclk", 32'(sclk[0]), 0);
        chk("idle_ss", 32'(ss[0]), 1);
        chk("idle_mosi", 32'(mosi[0]), 0);
        chk("idle_busy", 32'(busy[0]), 0);
        chk("idle_done", 32'(done[0]), 0);
        chk("idle_rx", 32'(rx[0]), 0);

        xfer0(8'hA5, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++)
            xfer0(8'($urandom), 8'($urandom), 1'b0);
        xfer0(8'h5A, 8'($urandom), 1'b1);

        // Abort after the 4th rising edge
        issue(0, 8'hC3, 8'($urandom), c0);
        #1;
        for (int k = 0; k < 200; k++) begin
            if (rises[0] >= 4) break;
            @(negedge clk);
            #1;
        end
        chk("abort_rise4_reached", 32'(rises[0] >= 4), 1);
        rst_L = 1'b0;
        void'(sb0.pop_back());
        #1;
        chk("abort_ss", 32'(ss[0]), 1);
        chk("abort_sclk", 32'(sclk[0]), 0);
        chk("abort_busy", 32'(busy[0]), 0);
        chk("abort_mosi", 32'(mosi[0]), 0);
        chk("abort_rx", 32'(rx[0]), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done[0]), 0);
        end
        rst_L = 1'b1;
        @(negedge clk);
        xfer0(8'h01, 8'($urandom), 1'b0);

        // Fast instance, back-to-back starts as soon as busy falls
        for (int i = 0; i < 5; i++) begin
            issue(1, 8'($urandom), 8'($urandom), c0);
            wait_idle(1, c0, 1'b1);
        end
        repeat (3) @(negedge clk);

`ifdef SPI_MASTER_BURST_EN
        hold0 = 1'b1;
        issue(0, 8'h12, 8'($urandom), c0);
        wait_idle(0, c0, 1'b0);
        chk("burst_ss_held", 32'(ss[0]), 0);
        issue(0, 8'h34, 8'($urandom), c0);
        wait_idle(0, c0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("burst_ss_held2", 32'(ss[0]), 0);
        end
        chk("burst_rises", rises_ss[0], 16);
        hold0 = 1'b0;
        @(negedge clk);
        chk("burst_ss_release", 32'(ss[0]), 1);
        wait_idle(0, c0, 1'b0);
        repeat (3) @(negedge clk);
`endif

        chk("sb0_empty", 32'(sb0.size()), 0);
        chk("sb1_empty", 32'(sb1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end

endmodule
